// File: rtl/stb_defs.sv
// stb_defs: shared definitions for the store buffer.
//   STB_DEPTH / STB_ADDR_W / STB_DATA_W : default geometry
//   stb_entry_t                         : entry field layout {is_byte, addr, data}
//   port_use_e                          : what the single memory port does this cycle
//   clog2()                             : pointer width helper
// Optional feature macro: STB_FWD_EN (store-to-load forwarding).
package stb_defs;

  localparam int unsigned STB_DEPTH  = 4;
  localparam int unsigned STB_ADDR_W = 10;
  localparam int unsigned STB_DATA_W = 32;

  typedef struct packed {
    logic                  is_byte;
    logic [STB_ADDR_W-1:0] addr;
    logic [STB_DATA_W-1:0] data;
  } stb_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_LOAD,
    PORT_DRAIN
  } port_use_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stb_match.sv
// stb_match: compares one buffered store against the current load.
// Ports:
//   i_valid, i_addr, i_byte : buffered entry (valid, byte address, byte/word size)
//   i_ld_addr, i_ld_byte    : load address and size
//   o_conflict              : entry is valid and its byte range intersects the load range
//   o_cover, o_k            : (STB_FWD_EN only) entry range contains the whole load range;
//                             o_k is the load byte offset inside the entry
// Ranges use ADDR_W+1 bit ends so a word at the top of memory does not wrap.
module stb_match
  import stb_defs::*;
#(
  parameter int unsigned ADDR_W = STB_ADDR_W
) (
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_byte,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic              i_ld_byte,
  output logic              o_conflict
`ifdef STB_FWD_EN
  ,
  output logic              o_cover,
  output logic [1:0]        o_k
`endif
);

  logic [ADDR_W:0] w_e_lo, w_e_hi, w_l_lo, w_l_hi;

  assign w_e_lo = {1'b0, i_addr};
  assign w_e_hi = w_e_lo + (i_byte ? (ADDR_W+1)'(0) : (ADDR_W+1)'(3));
  assign w_l_lo = {1'b0, i_ld_addr};
  assign w_l_hi = w_l_lo + (i_ld_byte ? (ADDR_W+1)'(0) : (ADDR_W+1)'(3));

  assign o_conflict = i_valid && (w_e_lo <= w_l_hi) && (w_l_lo <= w_e_hi);

`ifdef STB_FWD_EN
  assign o_cover = o_conflict && (w_e_lo <= w_l_lo) && (w_l_hi <= w_e_hi);
  // Only meaningful when covered; then the true offset is 0..3, so mod-4 is exact.
  assign o_k     = i_ld_addr[1:0] - i_addr[1:0];
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between MEM-stage load/store logic and the
// byte-addressed data memory. Stores are queued and drained to memory in cycles
// the port is not used by a load; loads overlapping a pending store stall.
// Optional feature macro: STB_FWD_EN -- a load fully covered by the youngest
// conflicting store is answered from the buffer instead of stalling.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   st_valid/addr/data/byte, st_ready : store request and accept (= room and no sync block)
//   ld_req/addr/byte, ld_stall, ld_data : load request and response
//   sync_req, sync_done            : drain request / buffer-empty indication
//   dm_addr/din/we/byteOp, dm_dout : single data-memory port (dm_dout combinational)
module store_buffer
  import stb_defs::*;
#(
  parameter int unsigned DEPTH  = STB_DEPTH,
  parameter int unsigned ADDR_W = STB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              st_byte,
  output logic              st_ready,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_byte,
  output logic              ld_stall,
  output logic [31:0]       ld_data,
  input  logic              sync_req,
  output logic              sync_done,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  output logic              dm_byteOp,
  input  logic [31:0]       dm_dout
);

  localparam int unsigned PW       = clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  logic              r_byte [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [31:0]       r_data [DEPTH];

  logic [DEPTH-1:0]  w_conflict;
  logic              w_any;
  logic              w_fwd;
  logic [31:0]       w_fwd_data;
  logic              w_push, w_drain;
  port_use_e         w_use;

`ifdef STB_FWD_EN
  logic [DEPTH-1:0]  w_cover;
  logic [1:0]        w_k [DEPTH];
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] w_rel;
    logic          w_valid;
    // Slot g holds a live store when its distance from head is below count.
    assign w_rel   = PW'(g) - r_head;
    assign w_valid = {1'b0, w_rel} < r_count;

    stb_match #(.ADDR_W(ADDR_W)) u_match (
      .i_valid    (w_valid),
      .i_addr     (r_addr[g]),
      .i_byte     (r_byte[g]),
      .i_ld_addr  (ld_addr),
      .i_ld_byte  (ld_byte),
      .o_conflict (w_conflict[g])
`ifdef STB_FWD_EN
      ,
      .o_cover    (w_cover[g]),
      .o_k        (w_k[g])
`endif
    );
  end

  assign w_any = |w_conflict;

`ifdef STB_FWD_EN
  logic [PW-1:0] w_young, w_idx;
  logic [7:0]    w_fwd_byte;

  // Walk oldest to youngest; the last conflicting slot seen is the youngest.
  always_comb begin
    w_young = r_head;
    w_idx   = r_head;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      w_idx = r_head + PW'(j);
      if (w_conflict[w_idx]) w_young = w_idx;
    end
  end

  always_comb begin
    w_fwd_byte = r_data[w_young][7:0];
    case (w_k[w_young])
      2'd1:    w_fwd_byte = r_data[w_young][15:8];
      2'd2:    w_fwd_byte = r_data[w_young][23:16];
      2'd3:    w_fwd_byte = r_data[w_young][31:24];
      default: w_fwd_byte = r_data[w_young][7:0];
    endcase
    w_fwd_data = ld_byte ? {{24{w_fwd_byte[7]}}, w_fwd_byte} : r_data[w_young];
  end

  assign w_fwd = w_any && w_cover[w_young];
`else
  assign w_fwd      = 1'b0;
  assign w_fwd_data = '0;
`endif

  assign sync_done = (r_count == '0);
  assign st_ready  = (r_count != FULL_CNT) && !(sync_req && (r_count != '0));
  assign w_push    = st_valid && st_ready;

  // A load that hits memory owns the port; otherwise (no load, stalled load or
  // forwarded load) the head drains. Draining is held off during reset so a
  // reset mid-operation leaves memory untouched.
  always_comb begin
    w_use = PORT_IDLE;
    if (ld_req && !w_any)            w_use = PORT_LOAD;
    else if (r_count != '0 && !rst)  w_use = PORT_DRAIN;
  end

  assign w_drain  = (w_use == PORT_DRAIN);
  assign ld_stall = ld_req && w_any && !w_fwd;

  always_comb begin
    dm_addr   = '0;
    dm_din    = '0;
    dm_we     = 1'b0;
    dm_byteOp = 1'b0;
    ld_data   = '0;
    case (w_use)
      PORT_LOAD: begin
        dm_addr   = ld_addr;
        dm_byteOp = ld_byte;
        ld_data   = dm_dout;
      end
      PORT_DRAIN: begin
        dm_addr   = r_addr[r_head];
        dm_din    = r_data[r_head];
        dm_byteOp = r_byte[r_head];
        dm_we     = 1'b1;
        if (w_fwd) ld_data = w_fwd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_byte[r_tail] <= st_byte;
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven directed vectors, hand sequences for reset,
// push/drain and sync behaviour, and randomized traffic against a queue-based
// reference model with its own copy of memory.
module tb_store_buffer;

  localparam int DEPTH = 4;
`ifdef STB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst;
  logic        st_valid, st_byte, st_ready;
  logic [9:0]  st_addr;
  logic [31:0] st_data;
  logic        ld_req, ld_byte, ld_stall;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        sync_req, sync_done;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we, dm_byteOp;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_stall(ld_stall), .ld_data(ld_data),
    .sync_req(sync_req), .sync_done(sync_done),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_byteOp(dm_byteOp),
    .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (dm_we) begin
      if (dm_byteOp) mem[dm_addr] <= dm_din[7:0];
      else for (int b = 0; b < 4; b++) mem[10'(dm_addr + 10'(b))] <= dm_din[8*b +: 8];
    end
  end
  always_comb begin
    if (dm_byteOp) dm_dout = {{24{mem[dm_addr][7]}}, mem[dm_addr]};
    else dm_dout = {mem[dm_addr + 10'd3], mem[dm_addr + 10'd2], mem[dm_addr + 10'd1], mem[dm_addr]};
  end

  // Reference model: pending stores in program order plus its own memory image
  typedef struct { int addr; bit is_byte; logic [31:0] data; } ent_t;
  ent_t       q[$];
  logic [7:0] mm [1024];

  int n_pass = 0, n_total = 0, cyc = 0;

  // Actual DUT outputs captured before the clock edge of the last step
  logic        a_ready, a_done, a_we, a_stall;
  logic [9:0]  a_addr;
  logic [31:0] a_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  function automatic logic [31:0] mread(input int a, input bit b);
    if (b) return {{24{mm[a][7]}}, mm[a]};
    return {mm[(a+3)%1024], mm[(a+2)%1024], mm[(a+1)%1024], mm[a]};
  endfunction

  function automatic logic [31:0] tb_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic step(input logic sv, input int sa, input logic [31:0] sd, input logic sb,
                      input logic lr, input int la, input logic lb,
                      input logic sr, input logic rs);
    int n, y, k, l_lo, l_hi, e_lo, e_hi;
    bit fwd, drain, load_mem, exp_ready, exp_stall;
    logic [31:0] exp_data, sel;
    ent_t e;
    @(negedge clk);
    st_valid = sv; st_addr = 10'(sa); st_data = sd; st_byte = sb;
    ld_req = lr; ld_addr = 10'(la); ld_byte = lb; sync_req = sr; rst = rs;
    #2;
    n = q.size();
    exp_ready = (n < DEPTH) && !(sr && n > 0);
    l_lo = la; l_hi = la + (lb ? 0 : 3);
    y = -1;
    for (int i = 0; i < n; i++) begin
      e_lo = q[i].addr; e_hi = e_lo + (q[i].is_byte ? 0 : 3);
      if (e_lo <= l_hi && l_lo <= e_hi) y = i;
    end
    fwd = 1'b0;
    if (FWD && y >= 0) begin
      e_lo = q[y].addr; e_hi = e_lo + (q[y].is_byte ? 0 : 3);
      fwd = (e_lo <= l_lo) && (l_hi <= e_hi);
    end
    drain = 1'b0; load_mem = 1'b0; exp_stall = 1'b0; exp_data = '0;
    if (lr && y < 0) begin
      load_mem = 1'b1;
      exp_data = mread(la, lb);
    end else begin
      if (lr && !fwd) exp_stall = 1'b1;
      if (lr && fwd) begin
        if (lb) begin
          k = la - q[y].addr;
          sel = q[y].data >> (8 * k);
          exp_data = {{24{sel[7]}}, sel[7:0]};
        end else exp_data = q[y].data;
      end
      drain = (n > 0) && !rs;
    end
    check("st_ready", st_ready, exp_ready);
    check("sync_done", sync_done, n == 0);
    check("dm_we", dm_we, drain);
    if (drain) begin
      check("drain_addr", dm_addr, q[0].addr);
      check("drain_din", dm_din, q[0].data);
      check("drain_byteop", dm_byteOp, q[0].is_byte);
    end
    if (load_mem) begin
      check("load_addr", dm_addr, la);
      check("load_byteop", dm_byteOp, lb);
    end
    if (lr) begin
      check("ld_stall", ld_stall, exp_stall);
      if (!exp_stall) check("ld_data", ld_data, exp_data);
    end
    a_ready = st_ready; a_done = sync_done; a_we = dm_we; a_stall = ld_stall;
    a_addr = dm_addr; a_data = ld_data;
    @(posedge clk);
    cyc++;
    if (drain) begin
      e = q.pop_front();
      if (e.is_byte) mm[e.addr] = e.data[7:0];
      else for (int b = 0; b < 4; b++) mm[(e.addr + b) % 1024] = e.data[8*b +: 8];
    end
    if (rs) q.delete();
    else if (sv && exp_ready) begin
      e.addr = sa; e.is_byte = sb; e.data = sd;
      q.push_back(e);
    end
  endtask

  typedef struct {
    logic sv; int sa; logic [31:0] sd; logic sb;
    logic lr; int la; logic lb;
    logic e_ready, e_done, e_we; int e_addr; logic e_stall; logic [31:0] e_data;
  } vec_t;

  vec_t tbl[19];

  initial begin
    //         sv  sa     sd            sb  lr  la     lb  rdy don we  addr   stall     data
    tbl[0]  = '{1, 'h000, 32'h11111111, 0,  1, 'h200, 0,  1,  1,  0,  0,     0,        32'h0};
    tbl[1]  = '{1, 'h004, 32'h22222222, 0,  1, 'h200, 0,  1,  0,  0,  0,     0,        32'h0};
    tbl[2]  = '{1, 'h008, 32'h33333333, 0,  1, 'h200, 0,  1,  0,  0,  0,     0,        32'h0};
    tbl[3]  = '{1, 'h00C, 32'h44444444, 0,  1, 'h200, 0,  1,  0,  0,  0,     0,        32'h0};
    tbl[4]  = '{0, 0,     32'h0,        0,  1, 'h200, 0,  0,  0,  0,  0,     0,        32'h0};
    tbl[5]  = '{0, 0,     32'h0,        0,  0, 0,     0,  0,  0,  1,  'h000, 0,        32'h0};
    tbl[6]  = '{0, 0,     32'h0,        0,  0, 0,     0,  1,  0,  1,  'h004, 0,        32'h0};
    tbl[7]  = '{0, 0,     32'h0,        0,  0, 0,     0,  1,  0,  1,  'h008, 0,        32'h0};
    tbl[8]  = '{0, 0,     32'h0,        0,  0, 0,     0,  1,  0,  1,  'h00C, 0,        32'h0};
    tbl[9]  = '{0, 0,     32'h0,        0,  0, 0,     0,  1,  1,  0,  0,     0,        32'h0};
    tbl[10] = '{1, 'h040, 32'hDEADBEEF, 0,  0, 0,     0,  1,  1,  0,  0,     0,        32'h0};
    tbl[11] = '{0, 0,     32'h0,        0,  1, 'h040, 0,  1,  0,  1,  'h040, !FWD,     32'hDEADBEEF};
    tbl[12] = '{0, 0,     32'h0,        0,  1, 'h040, 0,  1,  1,  0,  0,     0,        32'hDEADBEEF};
    tbl[13] = '{1, 'h080, 32'h000000F0, 0,  0, 0,     0,  1,  1,  0,  0,     0,        32'h0};
    tbl[14] = '{0, 0,     32'h0,        0,  1, 'h080, 1,  1,  0,  1,  'h080, !FWD,     32'hFFFFFFF0};
    tbl[15] = '{0, 0,     32'h0,        0,  1, 'h080, 1,  1,  1,  0,  0,     0,        32'hFFFFFFF0};
    tbl[16] = '{1, 'h081, 32'h0000007F, 1,  0, 0,     0,  1,  1,  0,  0,     0,        32'h0};
    tbl[17] = '{0, 0,     32'h0,        0,  1, 'h080, 0,  1,  0,  1,  'h081, 1,        32'h0};
    tbl[18] = '{0, 0,     32'h0,        0,  1, 'h080, 0,  1,  1,  0,  0,     0,        32'h00007FF0};

    for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; mm[i] = 8'h00; end
    rst = 1'b1; st_valid = 0; st_addr = '0; st_data = '0; st_byte = 0;
    ld_req = 0; ld_addr = '0; ld_byte = 0; sync_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #2;
    check("reset_st_ready", st_ready, 1'b1);
    check("reset_sync_done", sync_done, 1'b1);
    check("reset_dm_we", dm_we, 1'b0);
    check("reset_ld_stall", ld_stall, 1'b0);

    // Directed table
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].sb, tbl[i].lr, tbl[i].la, tbl[i].lb, 0, 0);
      check($sformatf("tbl%0d_ready", i), a_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_done", i), a_done, tbl[i].e_done);
      check($sformatf("tbl%0d_we", i), a_we, tbl[i].e_we);
      if (tbl[i].e_we) check($sformatf("tbl%0d_addr", i), a_addr, tbl[i].e_addr);
      if (tbl[i].lr) begin
        check($sformatf("tbl%0d_stall", i), a_stall, tbl[i].e_stall);
        if (!tbl[i].e_stall) check($sformatf("tbl%0d_data", i), a_data, tbl[i].e_data);
      end
    end

    // Push and drain in one cycle at count=2, then reset with 3 pending
    step(1, 'h300, 32'hA0A0A0A0, 0, 1, 'h200, 0, 0, 0);
    step(1, 'h304, 32'hB1B1B1B1, 0, 1, 'h200, 0, 0, 0);
    step(1, 'h308, 32'hC2C2C2C2, 0, 0, 0, 0, 0, 0);
    check("pd_we", a_we, 1'b1);
    check("pd_addr", a_addr, 10'h300);
    step(1, 'h30C, 32'hD3D3D3D3, 0, 1, 'h200, 0, 0, 0);
    check("pd_count2_ready", a_ready, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_no_write", a_we, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_done", a_done, 1'b1);
    check("rst_ready", a_ready, 1'b1);
    check("rst_mem_a", tb_word('h300), 32'hA0A0A0A0);
    check("rst_mem_b", tb_word('h304), 32'h0);
    check("rst_mem_c", tb_word('h308), 32'h0);
    check("rst_mem_d", tb_word('h30C), 32'h0);

    // sync_req with 3 pending and a store held
    for (int i = 0; i < 3; i++) step(1, 'h310 + 4*i, 32'h5000 + i, 0, 1, 'h200, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 'h320, 32'h600DF00D, 0, 0, 0, 0, 1, 0);
      check($sformatf("sync%0d_ready", i), a_ready, 1'b0);
      check($sformatf("sync%0d_done", i), a_done, 1'b0);
    end
    step(1, 'h320, 32'h600DF00D, 0, 0, 0, 0, 1, 0);
    check("sync_accept_ready", a_ready, 1'b1);
    check("sync_accept_done", a_done, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sync_drain_we", a_we, 1'b1);
    check("sync_drain_addr", a_addr, 10'h320);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sync_final_done", a_done, 1'b1);

    // Randomized traffic in a small address window to provoke overlaps
    for (int i = 0; i < 3000; i++) begin
      logic rs, lr;
      rs = ($urandom % 200) == 0;
      lr = rs ? 1'b0 : 1'($urandom % 2);
      step(1'($urandom % 2), int'($urandom_range(0, 31)), $urandom, 1'($urandom % 2),
           lr, int'($urandom_range(0, 31)), 1'($urandom % 2),
           ($urandom % 16) == 0, rs);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) check($sformatf("final_mem%0d", i), mem[i], mm[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
